// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable handshaked pipeline stage register (valid/ready, sync flush).
// Carries a control field that is forced to zero on bubbles and an unmasked data field.
// Define PIPE_SKID_EN for a two-entry (main + skid) build whose in_ready is registered.
// Without it the stage holds a single entry and in_ready depends combinationally on out_ready.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DATA_W = 69
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_count
);

  // Main entry: always the oldest held beat, drives the outputs.
  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;

  logic in_fire;
  logic out_fire;
  logic skid_valid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

`ifdef PIPE_SKID_EN
  // Skid entry: absorbs the one beat that arrives after out_ready drops.
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  // Straight from a flop, so long downstream stall wires never reach upstream logic.
  assign in_ready   = ~skid_valid_q;
  assign skid_valid = skid_valid_q;

  // Next state: flush beats everything; otherwise drain skid first, keeping arrival order.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no input can compete with the move.
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end else begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end
    end
  end

  // State registers for both entries, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  // Single entry: accept whenever the held beat leaves in the same cycle.
  assign in_ready   = ~main_valid_q | out_ready;
  assign skid_valid = 1'b0;

  // Next state: flush wins; otherwise replace, drain or load the single entry.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (in_fire) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
  end

  // State register for the single entry, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
    end
  end
`endif

  // Outputs: control is masked on bubbles so downstream never commits an invalid beat.
  always_comb begin
    out_valid = main_valid_q;
    out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    out_data  = main_data_q;
    out_count = {1'b0, main_valid_q} + {1'b0, skid_valid};
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue model of the stage plus directed scenarios.
module tb_pipe_stage_reg;
  localparam int CW = 2;
  localparam int DW = 69;
`ifdef PIPE_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    out_count;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  // Model: FIFO of held beats (capacity 1 or 2), upstream source queue, delivered log.
  beat_t         q[$];
  beat_t         src[$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] last_d = '0;
  int            n_vec = 0;
  int            n_err = 0;

  function automatic beat_t mk(input logic [CW-1:0] c, input logic [DW-1:0] d);
    beat_t b;
    b.c = c;
    b.d = d;
    return b;
  endfunction

  function automatic bit m_in_ready();
    if (Skid) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit            ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    ev = q.size() > 0;
    ec = ev ? q[0].c : '0;
    ed = ev ? q[0].d : last_d;
    chk("out_valid", DW'(out_valid), DW'(ev));
    chk("out_ctrl", DW'(out_ctrl), DW'(ec));
    chk("out_data", out_data, ed);
    chk("out_count", DW'(out_count), DW'(q.size()));
    chk("in_ready", DW'(in_ready), DW'(m_in_ready()));
  endtask

  // One clock: present the source head, advance the model at the edge, then compare.
  task automatic cycle();
    bit    inf;
    bit    outf;
    beat_t b;
    in_valid = src.size() > 0;
    if (src.size() > 0) begin
      in_ctrl = src[0].c;
      in_data = src[0].d;
    end
    inf  = in_valid && m_in_ready();
    outf = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      last_d = '0;
    end else begin
      if (outf) begin
        b = q.pop_front();
        got.push_back(b.d);
      end
      if (flush) q.delete();
      else if (inf) q.push_back(src[0]);
      if (q.size() > 0) last_d = q[0].d;
      if (inf) void'(src.pop_front());
    end
    #1;
    compare_all();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() > 0 || src.size() > 0) && k < 20) begin
      cycle();
      k++;
    end
    if (k >= 20) chk("drain_timeout", DW'(1), DW'(0));
  endtask

  initial begin
    // Reset state.
    #3;
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    chk("rst_out_count", DW'(out_count), DW'(0));
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Streaming 1..8 with ctrl 11.
    out_ready = 1'b1;
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      src.push_back(mk(2'b11, DW'(i)));
      cycle();
      if (i == 1) begin
        chk("stream_first_data", out_data, DW'(1));
        chk("stream_first_ctrl", DW'(out_ctrl), DW'(3));
      end
    end
    cycle();
    chk("stream_n", DW'(got.size()), DW'(8));
    for (int i = 0; i < 8; i++)
      if (i < got.size()) chk("stream_order", got[i], DW'(i + 1));

    // Backpressure: A loaded, out_ready drops, B and C offered.
    got.delete();
    src.push_back(mk(2'b01, DW'('hA)));
    cycle();
    out_ready = 1'b0;
    src.push_back(mk(2'b01, DW'('hB)));
    src.push_back(mk(2'b01, DW'('hC)));
    cycle();
    chk("bp_count", DW'(out_count), Skid ? DW'(2) : DW'(1));
    chk("bp_in_ready", DW'(in_ready), DW'(0));
    cycle();
    chk("bp_hold_data", out_data, DW'('hA));
    out_ready = 1'b1;
    #1;
    compare_all();
    if (!Skid) chk("ns_in_ready_follows", DW'(in_ready), DW'(1));
    drain();
    cycle();
    chk("bp_n", DW'(got.size()), DW'(3));
    if (got.size() == 3) begin
      chk("bp_order0", got[0], DW'('hA));
      chk("bp_order1", got[1], DW'('hB));
      chk("bp_order2", got[2], DW'('hC));
    end
    chk("bp_in_ready_back", DW'(in_ready), DW'(1));

    // Flush with the stage full and D offered; upstream then withdraws D.
    got.delete();
    out_ready = 1'b0;
    src.push_back(mk(2'b10, DW'('hE)));
    src.push_back(mk(2'b10, DW'('hF)));
    cycle();
    cycle();
    chk("fl_full_count", DW'(out_count), Skid ? DW'(2) : DW'(1));
    src.delete();
    src.push_back(mk(2'b11, DW'('hD)));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    src.delete();
    chk("fl_out_valid", DW'(out_valid), DW'(0));
    chk("fl_out_ctrl", DW'(out_ctrl), DW'(0));
    chk("fl_out_count", DW'(out_count), DW'(0));
    chk("fl_in_ready", DW'(in_ready), DW'(1));
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("fl_nothing_out", DW'(got.size()), DW'(0));

    // Flush while D handshakes in and G handshakes out: G delivered, D discarded.
    src.push_back(mk(2'b01, DW'('h6)));
    cycle();
    src.push_back(mk(2'b11, DW'('hD)));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    cycle();
    chk("fl2_n", DW'(got.size()), DW'(1));
    if (got.size() > 0) chk("fl2_g", got[0], DW'('h6));
    chk("fl2_out_valid", DW'(out_valid), DW'(0));

    // Bubble masking.
    src.push_back(mk(2'b11, DW'('hDEAD)));
    cycle();
    cycle();
    cycle();
    chk("bub_out_valid", DW'(out_valid), DW'(0));
    chk("bub_out_ctrl", DW'(out_ctrl), DW'(0));
    chk("bub_out_data", out_data, DW'('hDEAD));

    // Asynchronous reset mid-stream with the stage full.
    out_ready = 1'b0;
    src.push_back(mk(2'b11, DW'('h11)));
    src.push_back(mk(2'b11, DW'('h22)));
    cycle();
    cycle();
    chk("ar_pre_count", DW'(out_count), Skid ? DW'(2) : DW'(1));
    #2;
    rst = 1'b1;
    q.delete();
    src.delete();
    last_d = '0;
    #1;
    chk("ar_out_valid", DW'(out_valid), DW'(0));
    chk("ar_out_ctrl", DW'(out_ctrl), DW'(0));
    chk("ar_out_data", out_data, DW'(0));
    chk("ar_out_count", DW'(out_count), DW'(0));
    chk("ar_in_ready", DW'(in_ready), DW'(1));
    compare_all();
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    got.delete();
    src.push_back(mk(2'b01, DW'('h33)));
    src.push_back(mk(2'b10, DW'('h44)));
    drain();
    cycle();
    chk("ar_recover_n", DW'(got.size()), DW'(2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
